// File: rtl/alu_ctrl_seq_if.sv
// ID-to-EX control bus for alu_ctrl_seq: decoder inputs, stall back to ID,
// registered EX control and MDU sequencing status.
interface alu_ctrl_seq_if #(
    parameter int CTRL_W = 4
);
    logic              valid;
    logic              flush;
    logic [1:0]        aluOp;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic              stall;
    logic [CTRL_W-1:0] aluControl;
    logic              ctrlValid;
    logic              illegal;
    logic              mduStart;
    logic [1:0]        mduOp;
    logic              mduBusy;
    logic              mduDone;

    modport master (
        output valid, flush, aluOp, op, funct,
        input  stall, aluControl, ctrlValid, illegal, mduStart, mduOp, mduBusy, mduDone
    );

    modport slave (
        input  valid, flush, aluOp, op, funct,
        output stall, aluControl, ctrlValid, illegal, mduStart, mduOp, mduBusy, mduDone
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with a multi-cycle mult/div sequencer that
// stalls ID while the MDU is busy.
module alu_ctrl_seq #(
    parameter int CTRL_W     = 4,
    parameter int CNT_W      = 6,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input logic          clk,
    input logic          resetN,
    alu_ctrl_seq_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    state_t            state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              startNext;
    logic [1:0]        mduOpNext;
    logic              mduStartReg;
    logic [1:0]        mduOpReg;

    logic [3:0]        code;
    logic              legal;
    logic              isMdu;
    logic              isHilo;
    logic              accept;

    logic [CTRL_W-1:0] aluControlReg;
    logic              ctrlValidReg;
    logic              illegalReg;

    always_comb begin
        code   = 4'b0000;
        legal  = 1'b0;
        isMdu  = 1'b0;
        isHilo = 1'b0;
        case (bus.aluOp)
            2'b00: begin code = 4'b0010; legal = 1'b1; end
            2'b01: begin code = 4'b0110; legal = 1'b1; end
            2'b10: begin
                case (bus.funct)
                    6'b100000, 6'b100001: begin code = 4'b0010; legal = 1'b1; end
                    6'b100010, 6'b100011: begin code = 4'b0110; legal = 1'b1; end
                    6'b100100: begin code = 4'b0000; legal = 1'b1; end
                    6'b100101: begin code = 4'b0001; legal = 1'b1; end
                    6'b100110: begin code = 4'b1101; legal = 1'b1; end
                    6'b100111: begin code = 4'b1100; legal = 1'b1; end
                    6'b101010: begin code = 4'b0111; legal = 1'b1; end
                    6'b101011: begin code = 4'b1111; legal = 1'b1; end
                    6'b000000: begin code = 4'b1000; legal = 1'b1; end
                    6'b000010: begin code = 4'b1001; legal = 1'b1; end
                    6'b000011: begin code = 4'b1010; legal = 1'b1; end
                    6'b010000, 6'b010010: begin
                        code = 4'b0011; legal = 1'b1; isHilo = 1'b1;
                    end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        code = 4'b0010; legal = 1'b1; isMdu = 1'b1;
                    end
                    default: begin code = 4'b0000; legal = 1'b0; end
                endcase
            end
            default: begin
                case (bus.op)
                    6'b001100: begin code = 4'b0000; legal = 1'b1; end
                    6'b001101: begin code = 4'b0001; legal = 1'b1; end
                    6'b001110: begin code = 4'b1101; legal = 1'b1; end
                    6'b001010: begin code = 4'b0111; legal = 1'b1; end
                    6'b001011: begin code = 4'b1111; legal = 1'b1; end
                    default:   begin code = 4'b0000; legal = 1'b0; end
                endcase
            end
        endcase
    end

    // Anything touching HI/LO must wait for the MDU; flush overrides everything.
    assign bus.stall = bus.valid & (isMdu | isHilo) & (state == BUSY);
    assign accept    = bus.valid & ~bus.stall & ~bus.flush;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            aluControlReg <= '0;
            ctrlValidReg  <= 1'b0;
            illegalReg    <= 1'b0;
        end else begin
            ctrlValidReg <= accept;
            if (accept) begin
                aluControlReg <= CTRL_W'(code);
                illegalReg    <= ~legal;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            cnt         <= '0;
            mduStartReg <= 1'b0;
            mduOpReg    <= 2'b00;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            mduStartReg <= startNext;
            mduOpReg    <= mduOpNext;
        end
    end

    // funct[1] separates div/divu from mult/multu for the latency choice.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        startNext = 1'b0;
        mduOpNext = mduOpReg;
        case (state)
            IDLE: begin
                if (accept && isMdu) begin
                    stateNext = BUSY;
                    cntNext   = bus.funct[1] ? DIV_LAST : MUL_LAST;
                    startNext = 1'b1;
                    mduOpNext = bus.funct[1:0];
                end
            end
            default: begin
                if (cnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
        endcase
    end

    assign bus.aluControl = aluControlReg;
    assign bus.ctrlValid  = ctrlValidReg;
    assign bus.illegal    = illegalReg;
    assign bus.mduStart   = mduStartReg;
    assign bus.mduOp      = mduOpReg;
    assign bus.mduBusy    = (state == BUSY);
    assign bus.mduDone    = (state == BUSY) && (cnt == '0);
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU control unit for the pipelined MIPS core, sitting between the main decoder (ID stage) and the EX stage. It extends the combinational ALU decoder with a wider control code, immediate-logic decode, shift/xor/nor/sltu ops, and an explicit illegal flag. It also adds a multi-cycle sequencer that launches mult/div operations on the multiply/divide unit (MDU) and stalls ID while the MDU is busy.

## Interface
- CTRL_W, 4: aluControl width; must be ≥4; codes are zero-extended into upper bits.
- CNT_W, 6: MDU cycle-counter width.
- MUL_CYCLES, 4: MDU latency for mult/multu; 1 ≤ value ≤ 2^CNT_W.
- DIV_CYCLES, 32: MDU latency for div/divu; 1 ≤ value ≤ 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- valid  in  1  ID-stage instruction valid.
- flush  in  1  kill the current ID instruction (branch/jump redirect).
- aluOp  in  2  from main decoder: 00 add, 01 sub, 10 R-type (use funct), 11 immediate logic (use op).
- op  in  6  instruction opcode.
- funct  in  6  instruction funct field.
- stall  out  1  combinational; holds ID/IF this cycle.
- aluControl  out  CTRL_W  registered EX control code.
- ctrlValid  out  1  registered; EX instruction valid.
- illegal  out  1  registered; unrecognised funct/op.
- mduStart  out  1  registered one-cycle start pulse.
- mduOp  out  2  registered: 00 mult, 01 multu, 10 div, 11 divu.
- mduBusy  out  1  registered; MDU operation in flight.
- mduDone  out  1  combinational; last busy cycle.

## Operation
- Codes (low 4 bits): and 0000, or 0001, add 0010, hilo-pass 0011, sub 0110, slt 0111, sll 1000, srl 1001, sra 1010, nor 1100, xor 1101, sltu 1111.
- aluOp 00 → add; aluOp 01 → sub.
- aluOp 10 funct:
  - 100000/100001 → add; 100010/100011 → sub; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt; 101011 sltu.
  - 000000 sll; 000010 srl; 000011 sra.
  - 010000 mfhi and 010010 mflo → 0011.
  - 011000..011011 → MDU op (mduOp = funct[1:0]), aluControl 0010.
- aluOp 11 op: 001100 and; 001101 or; 001110 xor; 001010 slt; 001011 sltu.
- Any other funct/op: aluControl 0, illegal 1. No x outputs, ever.
- Accept = valid & !stall & !flush. On accept, the next edge registers aluControl, illegal, and ctrlValid=1.
- Not accepted: ctrlValid=0 (bubble); aluControl and illegal keep their previous values.
- needsMdu = decoded MDU op or mfhi/mflo. stall = valid & needsMdu & mduBusy.
- FSM IDLE/BUSY, counter cnt:
  - IDLE, accept of an MDU op: next edge goes to BUSY, cnt = latency−1, mduStart=1, mduOp latched, mduBusy=1.
  - BUSY: cnt decrements each edge. When cnt==0 the next edge returns to IDLE with mduBusy=0.
  - mduDone = BUSY & cnt==0.
- An MDU op is never accepted in BUSY, because stall blocks it. Flush does not abort an in-flight MDU op.
- An illegal instruction never starts the MDU.

## Timing
- Decode latency: 1 cycle (ID inputs at edge k → EX outputs after edge k).
- An MDU op accepted at edge k:
  - mduStart high for exactly the cycle after k.
  - mduBusy high for exactly latency cycles (after edges k..k+latency−1).
  - mduDone high in the last of those cycles.
- Latency 1: mduStart, mduBusy and mduDone all high in the same single cycle.
- stall is combinational from valid/op/funct/mduBusy. The stalled instruction is re-presented and is accepted on the first cycle mduBusy=0; back-to-back MDU ops therefore start with one cycle gap after mduDone.
- valid & flush in the same cycle: flush wins (bubble, no MDU start), even when stall is also high.
- Reset (any time, including mid-BUSY): immediately IDLE, cnt=0; aluControl=0, ctrlValid=0, illegal=0, mduStart=0, mduOp=0, mduBusy=0. stall and mduDone evaluate to 0. The in-flight op is abandoned.

## Test plan
- R-type sweep: aluOp=10 with each legal funct, valid=1 → next cycle aluControl matches the table, ctrlValid=1, illegal=0. funct=111111 → aluControl=0, illegal=1.
- Immediate/fixed: aluOp=11, op=001101 → 0001. aluOp=11, op=000000 → illegal=1. aluOp=00 → 0010. aluOp=01 → 0110.
- Multiply: mult accepted at edge k, MUL_CYCLES=4 → mduStart one cycle, mduOp=00, mduBusy 4 cycles, mduDone in the 4th. A mflo presented during busy → stall=1 until mduBusy falls, then ctrlValid=1 with 0011.
- Divide back-to-back: divu then div, DIV_CYCLES=32 → second start exactly 33 cycles after the first, mduOp 11 then 10. An add during busy → no stall.
- Flush: MDU op with flush=1 → no mduStart, ctrlValid=0. Flush while BUSY → counter continues, mduDone on schedule.
- Reset mid-op: resetN low at cnt=10 of a div → all outputs 0 immediately. After release, a mult starts normally.
